// File: rtl/higher_order_diff_ec.sv
// N-th order finite difference of folded ADC samples with warm-up gating and error restart.
// Optional macro HIGHER_ORDER_DIFF_SAT_EN: clamp on narrowing and report sat_flag; otherwise wrap.
module higher_order_diff_ec #(
  parameter int WIDTH           = 32,
  parameter int ORDER           = 2,
  parameter int FRACTIONAL_BITS = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic                    error_in,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] diff_out,
  output logic                    primed,
  output logic                    sat_flag
);

  localparam int IW = WIDTH + ORDER;

  if (ORDER < 1 || ORDER > 4) begin : g_order_check
    $error("higher_order_diff_ec: ORDER must be in 1..4");
  end
  if (FRACTIONAL_BITS < 0 || FRACTIONAL_BITS >= WIDTH) begin : g_frac_check
    $error("higher_order_diff_ec: FRACTIONAL_BITS must be in 0..WIDTH-1");
  end

  typedef enum logic {FILL, RUN} state_t;

  state_t     state;
  logic [1:0] fill_cnt;
  logic       accept;
  logic       drop;

  // Per-stage registers: index i holds the output of difference stage i.
  logic signed [IW-1:0] d_p    [ORDER];
  logic signed [IW-1:0] hist_p [ORDER];
  logic [ORDER-1:0]     vld_p;
  logic [ORDER-1:0]     qual_p;

  logic signed [IW-1:0] stg_in [ORDER];
  logic [ORDER-1:0]     stg_vld;
  logic [ORDER-1:0]     stg_qual;

  logic [WIDTH:0]       narrowed;

  function automatic logic [WIDTH:0] narrow(input logic signed [IW-1:0] v);
`ifdef HIGHER_ORDER_DIFF_SAT_EN
    logic signed [IW-1:0] max_v;
    logic signed [IW-1:0] min_v;
    max_v = {{(ORDER+1){1'b0}}, {(WIDTH-1){1'b1}}};
    min_v = {{(ORDER+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if (v > max_v)
      return {1'b1, max_v[WIDTH-1:0]};
    else if (v < min_v)
      return {1'b1, min_v[WIDTH-1:0]};
    else
      return {1'b0, v[WIDTH-1:0]};
`else
    return {1'b0, v[WIDTH-1:0]};
`endif
  endfunction

  assign accept   = valid_in & ~error_in;
  assign drop     = valid_in & error_in;
  assign primed   = (state == RUN);
  assign narrowed = narrow(d_p[ORDER-1]);

  always_comb begin
    stg_in[0]   = {{ORDER{data_in[WIDTH-1]}}, data_in};
    stg_vld[0]  = accept;
    stg_qual[0] = accept && (state == RUN);
    for (int i = 1; i < ORDER; i++) begin
      stg_in[i]   = d_p[i-1];
      stg_vld[i]  = vld_p[i-1];
      stg_qual[i] = qual_p[i-1];
    end
  end

  // Warm-up control: ORDER contiguous good samples must be seen before tagging outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else if (clk_en) begin
      if (drop) begin
        state    <= FILL;
        fill_cnt <= '0;
      end else if (accept && state == FILL) begin
        if (fill_cnt == 2'(ORDER - 1)) begin
          state    <= RUN;
          fill_cnt <= '0;
        end else begin
          fill_cnt <= fill_cnt + 2'd1;
        end
      end
    end
  end

  // Difference stages: history only moves on a valid slot, so bubbles are transparent.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p  <= '0;
      qual_p <= '0;
      for (int i = 0; i < ORDER; i++) begin
        d_p[i]    <= '0;
        hist_p[i] <= '0;
      end
    end else if (clk_en) begin
      vld_p  <= stg_vld;
      qual_p <= stg_qual;
      for (int i = 0; i < ORDER; i++) begin
        if (stg_vld[i]) begin
          d_p[i]    <= stg_in[i] - hist_p[i];
          hist_p[i] <= stg_in[i];
        end
      end
    end
  end

  // Output register: data and flag hold between qualified results.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      diff_out  <= '0;
      sat_flag  <= 1'b0;
    end else if (clk_en) begin
      valid_out <= qual_p[ORDER-1];
      if (qual_p[ORDER-1]) begin
        diff_out <= narrowed[WIDTH-1:0];
        sat_flag <= narrowed[WIDTH];
      end
    end
  end

endmodule
